// File: rtl/eth_mac_csr_bridge.sv
// -----------------------------------------------------------------------------
// eth_mac_csr_bridge
//
// Purpose:
//   Bridges a single command/response request port onto NUM_PORTS Avalon-MM
//   MAC CSR slaves. It handles one access at a time. Each access targets one
//   port and drives one read or write strobe until that port drops
//   waitrequest. If waitrequest stays high for TIMEOUT_CYC strobe cycles, the
//   access is aborted. A request to a port index that does not exist finishes
//   at once with a bad-port flag. Timeouts and bad-port requests are counted in
//   a saturating 16-bit error counter.
//
// Handshake:
//   A request is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
//   cmd_ready is high only in IDLE, and cmd_valid is ignored at every other
//   time. Each accepted request produces exactly one rsp_valid pulse, unless
//   reset intervenes. rsp_rdata, rsp_timeout and rsp_badport are valid while
//   rsp_valid=1 and hold their values until the next pulse.
//
// Ports:
//   prmgmt_ctrl_clk     sole clock, rising edge
//   prmgmt_arst         synchronous active-high reset
//   cmd_*               request (valid/ready), write flag, port, address, data
//   rsp_*               completion pulse, read data, timeout / bad-port flags
//   err_count, err_clr  saturating error counter and its synchronous clear
//   csr_*               per-port Avalon-MM strobes, shared address/writedata,
//                       packed readdata, per-port waitrequest
//   dbg_state           current FSM state (0=IDLE, 1=ACCESS, 2=DONE)
// -----------------------------------------------------------------------------
module eth_mac_csr_bridge #(
    parameter  int NUM_PORTS   = 4,
    parameter  int ADDR_W      = 16,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int SEL_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    prmgmt_ctrl_clk,
    input  logic                    prmgmt_arst,
    // request
    input  logic                    cmd_valid,
    input  logic                    cmd_write,
    input  logic [SEL_W-1:0]        cmd_port,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [31:0]             cmd_wdata,
    output logic                    cmd_ready,
    // response
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_timeout,
    output logic                    rsp_badport,
    // error counter
    output logic [15:0]             err_count,
    input  logic                    err_clr,
    // MAC CSR slaves
    output logic [NUM_PORTS-1:0]    csr_read,
    output logic [NUM_PORTS-1:0]    csr_write,
    output logic [ADDR_W-1:0]       csr_address,
    output logic [31:0]             csr_writedata,
    input  logic [NUM_PORTS*32-1:0] csr_readdata,
    input  logic [NUM_PORTS-1:0]    csr_waitrequest,
    // debug
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // The last strobe cycle before an abort is the one where the counter
    // holds TIMEOUT_CYC-1. The counter is 0 in the first ACCESS cycle.
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYC - 1);

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic [SEL_W-1:0]       port_q, port_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   csr_read_q, csr_read_d;
    logic [NUM_PORTS-1:0]   csr_write_q, csr_write_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   rsp_badport_q, rsp_badport_d;
    logic [15:0]            err_count_q, err_count_d;

    logic                   cmd_port_ok;
    logic [NUM_PORTS-1:0]   cmd_port_onehot;
    logic                   sel_wait;
    logic [31:0]            sel_rdata;

    // Decode the incoming port index into a one-hot strobe vector. An
    // out-of-range index gives an all-zero vector and a cleared cmd_port_ok.
    always_comb begin
        cmd_port_ok     = 1'b0;
        cmd_port_onehot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(cmd_port) == p) begin
                cmd_port_ok        = 1'b1;
                cmd_port_onehot[p] = 1'b1;
            end
        end
    end

    // Select the waitrequest and readdata of the registered target port.
    // The loop form keeps a bad index from addressing past the bus.
    always_comb begin
        sel_wait  = 1'b1;
        sel_rdata = 32'h0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(port_q) == p) begin
                sel_wait  = csr_waitrequest[p];
                sel_rdata = csr_readdata[p*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        port_d        = port_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        csr_read_d    = csr_read_q;
        csr_write_d   = csr_write_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_badport_d = rsp_badport_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    write_d = cmd_write;
                    port_d  = cmd_port;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = 16'h0;
                    if (cmd_port_ok) begin
                        state_d     = ST_ACCESS;
                        csr_read_d  = cmd_write ? '0 : cmd_port_onehot;
                        csr_write_d = cmd_write ? cmd_port_onehot : '0;
                    end else begin
                        // A nonexistent slave cannot be strobed, so respond
                        // on the next cycle.
                        state_d       = ST_DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = 32'h0;
                        rsp_timeout_d = 1'b0;
                        rsp_badport_d = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + 16'h1;
                // Completion is checked before the timeout. If waitrequest
                // drops on the limit cycle, the access is a normal completion.
                if (!sel_wait) begin
                    state_d       = ST_DONE;
                    csr_read_d    = '0;
                    csr_write_d   = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = write_q ? 32'h0 : sel_rdata;
                    rsp_timeout_d = 1'b0;
                    rsp_badport_d = 1'b0;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    state_d       = ST_DONE;
                    csr_read_d    = '0;
                    csr_write_d   = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'hFFFF_FFFF;
                    rsp_timeout_d = 1'b1;
                    rsp_badport_d = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                csr_read_d  = '0;
                csr_write_d = '0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Error counter: clear wins over a same-cycle increment, and the count
    // saturates instead of wrapping.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = 16'h0;
        end else if (rsp_valid_q && (rsp_timeout_q || rsp_badport_q) &&
                     (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'h1;
        end
    end

    always_ff @(posedge prmgmt_ctrl_clk) begin
        if (prmgmt_arst) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            port_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= 32'h0;
            cnt_q         <= 16'h0;
            csr_read_q    <= '0;
            csr_write_q   <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_timeout_q <= 1'b0;
            rsp_badport_q <= 1'b0;
            err_count_q   <= 16'h0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            port_q        <= port_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            csr_read_q    <= csr_read_d;
            csr_write_q   <= csr_write_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_badport_q <= rsp_badport_d;
            err_count_q   <= err_count_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign rsp_badport   = rsp_badport_q;
    assign err_count     = err_count_q;
    assign csr_read      = csr_read_q;
    assign csr_write     = csr_write_q;
    assign csr_address   = addr_q;
    assign csr_writedata = wdata_q;
    assign dbg_state     = state_q;

endmodule
